// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_pkg
//  Brief    : Shared types and helpers for the burst memory port arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_CMD  = 2'd1,
        RD_DATA = 2'd2,
        WR_DATA = 2'd3
    } arb_state_t;

    // Default width of the burst length field (encodes beats-1).
    localparam int DEFAULT_BURSTLEN_WIDTH = 2;

    // Largest requester count supported and the matching index width.
    localparam int MAX_REQ = 4;
    localparam int IDX_W   = 2;

    // Round-robin pick: first set request at or after ptr, wrapping at nreq.
    // Returns ptr when nothing is requesting; callers qualify with |req.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [IDX_W-1:0]   ptr,
        input int                 nreq
    );
        logic [IDX_W-1:0] pick;
        int               idx;
        pick = ptr;
        // Walk from farthest to nearest so the nearest requester wins.
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < nreq) begin
                idx = (int'(ptr) + k) % nreq;
                if (req[idx[IDX_W-1:0]]) begin
                    pick = idx[IDX_W-1:0];
                end
            end
        end
        return pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Brief    : Combinational round-robin pick with a registered priority
//             pointer that advances past the requester just served.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import mem_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [NREQ-1:0]  req,
    input  logic             advance,
    input  logic [IDX_W-1:0] adv_idx,
    output logic [IDX_W-1:0] pick,
    output logic             any_req
);

    logic [IDX_W-1:0]   rr_ptr_q;
    logic [IDX_W-1:0]   rr_ptr_d;
    logic [MAX_REQ-1:0] req_pad;

    // Widen the request vector to the fixed width the pick helper expects.
    always_comb begin
        req_pad = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_pad[i] = req[i];
        end
    end

    // Winner selection, searching upward from the priority pointer.
    always_comb begin
        pick    = rr_pick(req_pad, rr_ptr_q, NREQ);
        any_req = |req;
    end

    // After a completed burst, priority moves to the next requester.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (advance) begin
            rr_ptr_d = (adv_idx == IDX_W'(NREQ - 1)) ? '0 : adv_idx + 1'b1;
        end
    end

    // Priority pointer register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Brief    : Shares one burst memory port between NREQ cache masters.
//             Round-robin arbitration; the grant is held for a whole burst.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int NREQ           = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int BURSTLEN_WIDTH = DEFAULT_BURSTLEN_WIDTH
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [NREQ*ADDR_WIDTH-1:0]     req_addr,
    input  logic [NREQ*BURSTLEN_WIDTH-1:0] req_burst_len,
    input  logic [NREQ-1:0]                req_rd,
    input  logic [NREQ-1:0]                req_wr,
    input  logic [NREQ*DATA_WIDTH-1:0]     req_wr_data,
    output logic [NREQ-1:0]                req_waitrequest,
    output logic [NREQ-1:0]                req_rd_valid,
    output logic [DATA_WIDTH-1:0]          req_rd_data,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    output logic [BURSTLEN_WIDTH-1:0]      mem_burst_len,
    output logic                           mem_rd,
    output logic                           mem_wr,
    output logic [DATA_WIDTH-1:0]          mem_wr_data,
    input  logic                           mem_waitrequest,
    input  logic                           mem_rd_valid,
    input  logic [DATA_WIDTH-1:0]          mem_rd_data
);

    localparam logic [31:0] STAT_MAX = '1;

    arb_state_t                state_q, state_d;
    logic [IDX_W-1:0]          grant_q, grant_d;
    logic [BURSTLEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic [31:0]               stat_grants_q [NREQ];
    logic [31:0]               stat_grants_d [NREQ];

    logic [IDX_W-1:0]          pick;
    logic                      any_req;
    logic                      advance;

    logic                      pick_rd;
    logic [BURSTLEN_WIDTH-1:0] pick_len;
    logic                      g_rd;
    logic                      g_wr;
    logic [ADDR_WIDTH-1:0]     g_addr;
    logic [BURSTLEN_WIDTH-1:0] g_len;
    logic [DATA_WIDTH-1:0]     g_wdata;

    rr_arbiter #(
        .NREQ    (NREQ)
    ) u_rr (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (req_rd | req_wr),
        .advance (advance),
        .adv_idx (grant_q),
        .pick    (pick),
        .any_req (any_req)
    );

    // Read data is broadcast; only the granted requester sees rd_valid.
    assign req_rd_data = mem_rd_data;

    // Fields of the arbitration winner and of the currently granted master.
    always_comb begin
        pick_rd  = 1'b0;
        pick_len = '0;
        g_rd     = 1'b0;
        g_wr     = 1'b0;
        g_addr   = '0;
        g_len    = '0;
        g_wdata  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick == i[IDX_W-1:0]) begin
                pick_rd  = req_rd[i];
                pick_len = req_burst_len[i*BURSTLEN_WIDTH +: BURSTLEN_WIDTH];
            end
            if (grant_q == i[IDX_W-1:0]) begin
                g_rd    = req_rd[i];
                g_wr    = req_wr[i];
                g_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                g_len   = req_burst_len[i*BURSTLEN_WIDTH +: BURSTLEN_WIDTH];
                g_wdata = req_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state, beat counting, statistics and port muxing.
    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        beat_cnt_d      = beat_cnt_q;
        advance         = 1'b0;
        stat_grants_d   = stat_grants_q;
        mem_addr        = '0;
        mem_burst_len   = '0;
        mem_rd          = 1'b0;
        mem_wr          = 1'b0;
        mem_wr_data     = '0;
        req_waitrequest = '1;
        req_rd_valid    = '0;
        case (state_q)
            IDLE: begin
                // Arbitration cycle: nothing goes to memory yet.
                if (any_req) begin
                    grant_d    = pick;
                    beat_cnt_d = pick_len;
                    state_d    = pick_rd ? RD_CMD : WR_DATA;
                    for (int i = 0; i < NREQ; i++) begin
                        if (pick == i[IDX_W-1:0] && stat_grants_q[i] != STAT_MAX) begin
                            stat_grants_d[i] = stat_grants_q[i] + 32'd1;
                        end
                    end
                end
            end
            RD_CMD: begin
                mem_addr      = g_addr;
                mem_burst_len = g_len;
                mem_rd        = g_rd;
                for (int i = 0; i < NREQ; i++) begin
                    if (grant_q == i[IDX_W-1:0]) begin
                        req_waitrequest[i] = mem_waitrequest;
                    end
                end
                if (g_rd && !mem_waitrequest) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                for (int i = 0; i < NREQ; i++) begin
                    if (grant_q == i[IDX_W-1:0]) begin
                        req_rd_valid[i] = mem_rd_valid;
                    end
                end
                if (mem_rd_valid) begin
                    if (beat_cnt_q == '0) begin
                        state_d = IDLE;
                        advance = 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_q - 1'b1;
                    end
                end
            end
            WR_DATA: begin
                // A master that drops wr mid-burst simply stalls the burst.
                mem_addr      = g_addr;
                mem_burst_len = g_len;
                mem_wr        = g_wr;
                mem_wr_data   = g_wdata;
                for (int i = 0; i < NREQ; i++) begin
                    if (grant_q == i[IDX_W-1:0]) begin
                        req_waitrequest[i] = mem_waitrequest;
                    end
                end
                if (g_wr && !mem_waitrequest) begin
                    if (beat_cnt_q == '0) begin
                        state_d = IDLE;
                        advance = 1'b1;
                    end else begin
                        beat_cnt_d = beat_cnt_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, grant, beat counter and statistics registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            beat_cnt_q <= '0;
            for (int i = 0; i < NREQ; i++) begin
                stat_grants_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            beat_cnt_q <= beat_cnt_d;
            for (int i = 0; i < NREQ; i++) begin
                stat_grants_q[i] <= stat_grants_d[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Brief    : Scoreboard bench for mem_arbiter with memory and master models.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int NREQ      = 2;
    localparam int AW        = 32;
    localparam int DW        = 32;
    localparam int BLW       = 2;
    localparam int MEM_WORDS = 4096;

    logic                  clock = 1'b0;
    logic                  reset_n = 1'b0;
    logic [NREQ*AW-1:0]    req_addr;
    logic [NREQ*BLW-1:0]   req_burst_len;
    logic [NREQ-1:0]       req_rd;
    logic [NREQ-1:0]       req_wr;
    logic [NREQ*DW-1:0]    req_wr_data;
    logic [NREQ-1:0]       req_waitrequest;
    logic [NREQ-1:0]       req_rd_valid;
    logic [DW-1:0]         req_rd_data;
    logic [AW-1:0]         mem_addr;
    logic [BLW-1:0]        mem_burst_len;
    logic                  mem_rd;
    logic                  mem_wr;
    logic [DW-1:0]         mem_wr_data;
    logic                  mem_waitrequest;
    logic                  mem_rd_valid;
    logic [DW-1:0]         mem_rd_data;

    always #5 clock = ~clock;

    mem_arbiter #(
        .NREQ(NREQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURSTLEN_WIDTH(BLW)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .req_addr(req_addr), .req_burst_len(req_burst_len),
        .req_rd(req_rd), .req_wr(req_wr), .req_wr_data(req_wr_data),
        .req_waitrequest(req_waitrequest), .req_rd_valid(req_rd_valid),
        .req_rd_data(req_rd_data),
        .mem_addr(mem_addr), .mem_burst_len(mem_burst_len),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wr_data(mem_wr_data),
        .mem_waitrequest(mem_waitrequest), .mem_rd_valid(mem_rd_valid),
        .mem_rd_data(mem_rd_data)
    );

    typedef struct packed {
        logic         id;
        logic         is_wr;
        logic [31:0]  addr;
        logic [1:0]   len;
        logic [127:0] data;
    } cmd_t;

    typedef struct packed {
        logic        id;
        logic [31:0] data;
    } exp_t;

    cmd_t        cmd_q[$];
    exp_t        exp_q[$];
    int          grant_log[$];
    int          rd_pend[$];
    logic [31:0] mem     [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];
    int          beats_seen [NREQ];
    int          exp_stat   [NREQ];
    logic        busy [NREQ];
    cmd_t        cur  [NREQ];
    int          beat [NREQ];
    int          wr_beat = 0;
    bit          stall_en = 1'b0;
    bit          t3_watch = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'(a[13:2]);
    endfunction

    task automatic add_cmd(input int id, input bit is_wr, input logic [31:0] addr,
                           input int len, input logic [127:0] data);
        cmd_t c;
        c.id    = id[0];
        c.is_wr = is_wr;
        c.addr  = addr;
        c.len   = len[1:0];
        c.data  = data;
        cmd_q.push_back(c);
        exp_stat[id]++;
    endtask

    // Records which master the memory saw a command from, and checks routing.
    task automatic log_grant();
        int who;
        int n_low;
        who   = -1;
        n_low = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (!req_waitrequest[i]) begin
                who = i;
                n_low++;
            end
        end
        check("one_master_unstalled", n_low, 1);
        if (who >= 0) begin
            check("mem_addr_routed", mem_addr, req_addr[who*AW +: AW]);
            grant_log.push_back(who);
            if (t3_watch && who == 1) check("req1_cmd_after_req0_beats", beats_seen[0], 4);
        end
    endtask

    // Memory model: accepts commands, stores writes, returns read beats later.
    initial begin : mem_model
        mem_waitrequest = 1'b0;
        mem_rd_valid    = 1'b0;
        mem_rd_data     = '0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                rd_pend.delete();
                wr_beat = 0;
            end else begin
                if (mem_rd && !mem_waitrequest) begin
                    log_grant();
                    for (int b = 0; b <= int'(mem_burst_len); b++) rd_pend.push_back(widx(mem_addr) + b);
                end
                if (mem_wr && !mem_waitrequest) begin
                    if (wr_beat == 0) log_grant();
                    mem[widx(mem_addr) + wr_beat] = mem_wr_data;
                    wr_beat = (wr_beat == int'(mem_burst_len)) ? 0 : wr_beat + 1;
                end
                if (mem_rd_valid && rd_pend.size() > 0) void'(rd_pend.pop_front());
            end
            @(posedge clock);
            #1;
            mem_waitrequest = stall_en && ($urandom_range(0, 2) == 0);
            if (reset_n && rd_pend.size() > 0 && $urandom_range(0, 3) != 0) begin
                mem_rd_valid = 1'b1;
                mem_rd_data  = mem[rd_pend[0]];
            end else begin
                mem_rd_valid = 1'b0;
                mem_rd_data  = '0;
            end
        end
    end

    // Master models: issue queued commands in program order; the reference
    // model (ref_mem, exp_q) is updated at the moment a command is issued.
    initial begin : masters
        req_rd = '0; req_wr = '0; req_addr = '0; req_burst_len = '0; req_wr_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            busy[i] = 1'b0; beat[i] = 0; cur[i] = '0;
        end
        forever begin
            @(negedge clock);
            for (int i = 0; i < NREQ; i++) begin
                if (!reset_n) begin
                    busy[i] = 1'b0;
                end else if (busy[i] && !req_waitrequest[i]) begin
                    if (cur[i].is_wr && req_wr[i]) begin
                        if (beat[i] == int'(cur[i].len)) busy[i] = 1'b0;
                        else beat[i]++;
                    end else if (!cur[i].is_wr && req_rd[i]) begin
                        busy[i] = 1'b0;
                    end
                end
            end
            @(posedge clock);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (!busy[i] && reset_n) begin
                    int k;
                    k = -1;
                    for (int j = 0; j < cmd_q.size(); j++) if (k < 0 && int'(cmd_q[j].id) == i) k = j;
                    if (k >= 0) begin
                        cur[i]  = cmd_q[k];
                        cmd_q.delete(k);
                        busy[i] = 1'b1;
                        beat[i] = 0;
                        for (int b = 0; b <= int'(cur[i].len); b++) begin
                            if (cur[i].is_wr) ref_mem[widx(cur[i].addr) + b] = cur[i].data[b*32 +: 32];
                            else exp_q.push_back('{id: i[0], data: ref_mem[widx(cur[i].addr) + b]});
                        end
                    end
                end
                req_rd[i] = busy[i] && !cur[i].is_wr;
                req_wr[i] = busy[i] && cur[i].is_wr;
                req_addr[i*AW +: AW]           = busy[i] ? cur[i].addr : '0;
                req_burst_len[i*BLW +: BLW]    = busy[i] ? cur[i].len : '0;
                req_wr_data[i*DW +: DW]        = busy[i] ? cur[i].data[beat[i]*32 +: 32] : '0;
            end
        end
    end

    // Monitor: every read beat a master receives is popped and compared.
    initial begin : monitor
        forever begin
            @(negedge clock);
            if (reset_n) begin
                for (int i = 0; i < NREQ; i++) begin
                    if (req_rd_valid[i]) begin
                        int k;
                        k = -1;
                        for (int j = 0; j < exp_q.size(); j++) if (k < 0 && int'(exp_q[j].id) == i) k = j;
                        beats_seen[i]++;
                        check($sformatf("rd_beat_expected_req%0d", i), k >= 0, 1'b1);
                        if (k >= 0) begin
                            check($sformatf("rd_data_req%0d", i), req_rd_data, exp_q[k].data);
                            exp_q.delete(k);
                        end
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        cmd_q.delete(); exp_q.delete(); grant_log.delete();
        for (int i = 0; i < NREQ; i++) begin
            beats_seen[i] = 0; exp_stat[i] = 0;
        end
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int cyc;
        cyc = 0;
        while ((cmd_q.size() != 0 || busy[0] || busy[1] || exp_q.size() != 0) && cyc < 3000) begin
            @(posedge clock);
            cyc++;
        end
        check({name, "_completes"}, cyc < 3000, 1'b1);
        repeat (3) @(posedge clock);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int ptr;
        int left [NREQ];
        int cyc;
        for (int w = 0; w < MEM_WORDS; w++) begin
            mem[w] = w; ref_mem[w] = w;
        end
        do_reset();

        // Idle: no requests, everything quiet.
        repeat (10) begin
            @(negedge clock);
            check("idle_outputs", {mem_rd, mem_wr, req_waitrequest, req_rd_valid}, 6'b001100);
        end
        check("idle_mem_addr", mem_addr, 32'h0);

        // Single 4-beat read from master 0.
        add_cmd(0, 1'b0, 32'h100, 3, '0);
        wait_idle("single_read");
        check("single_read_beats_req0", beats_seen[0], 4);
        check("single_read_beats_req1", beats_seen[1], 0);

        // Simultaneous reads after reset: master 0 first, master 1 after its burst.
        do_reset();
        @(negedge clock);
        add_cmd(0, 1'b0, 32'h100, 3, '0);
        add_cmd(1, 1'b0, 32'h240, 3, '0);
        t3_watch = 1'b1;
        wait_idle("simultaneous");
        t3_watch = 1'b0;
        check("simultaneous_grants", grant_log.size(), 2);
        if (grant_log.size() == 2) begin
            check("simultaneous_first", grant_log[0], 0);
            check("simultaneous_second", grant_log[1], 1);
        end

        // Continuous requests: order follows round-robin from pointer 0.
        do_reset();
        @(negedge clock);
        for (int n = 0; n < 3; n++) begin
            add_cmd(0, 1'b0, 32'h300 + n * 16, 3, '0);
            add_cmd(1, 1'b0, 32'h400 + n * 16, 3, '0);
        end
        wait_idle("continuous");
        check("continuous_grants", grant_log.size(), 6);
        ptr = 0;
        left[0] = 3; left[1] = 3;
        for (int n = 0; n < 6 && n < grant_log.size(); n++) begin
            int w;
            w = -1;
            for (int k = 0; k < NREQ; k++) if (w < 0 && left[(ptr + k) % NREQ] > 0) w = (ptr + k) % NREQ;
            check($sformatf("continuous_order_%0d", n), grant_log[n], w);
            left[w]--;
            ptr = (w + 1) % NREQ;
        end
        check("stat_grants_0", dut.stat_grants_q[0], exp_stat[0]);
        check("stat_grants_1", dut.stat_grants_q[1], exp_stat[1]);

        // Stalled write from master 1, read back by master 0.
        stall_en = 1'b1;
        add_cmd(1, 1'b1, 32'h2000, 3, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
        wait_idle("stalled_write");
        for (int k = 0; k < 4; k++) check($sformatf("mem_word_%0d", k), mem[32'h800 + k], ref_mem[32'h800 + k]);
        add_cmd(0, 1'b0, 32'h2000, 3, '0);
        wait_idle("read_back");

        // Random mixed traffic, each master in its own address region.
        for (int n = 0; n < 24; n++) begin
            int id, len;
            id  = $urandom_range(0, 1);
            len = $urandom_range(0, 3);
            add_cmd(id, $urandom_range(0, 1) == 1, (id == 0 ? 32'h1000 : 32'h1400) + 32'($urandom_range(0, 60)) * 4,
                    len, {$urandom, $urandom, $urandom, $urandom});
        end
        wait_idle("random");
        check("stat_after_random_0", dut.stat_grants_q[0], exp_stat[0]);
        check("stat_after_random_1", dut.stat_grants_q[1], exp_stat[1]);

        // Pointer now favours master 1; a reset mid-burst must return it to 0.
        stall_en = 1'b0;
        add_cmd(0, 1'b0, 32'h300, 0, '0);
        wait_idle("pointer_setup");
        for (int i = 0; i < NREQ; i++) beats_seen[i] = 0;
        add_cmd(0, 1'b0, 32'h100, 3, '0);
        cyc = 0;
        while (beats_seen[0] < 2 && cyc < 500) begin
            @(negedge clock);
            cyc++;
        end
        check("midburst_two_beats", beats_seen[0], 2);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_ctrl", {mem_rd, mem_wr, req_waitrequest, req_rd_valid}, 6'b001100);
        check("async_reset_bus", {mem_addr, mem_burst_len, mem_wr_data}, 66'h0);
        cmd_q.delete(); exp_q.delete(); grant_log.delete();
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        add_cmd(0, 1'b0, 32'h100, 0, '0);
        add_cmd(1, 1'b0, 32'h200, 0, '0);
        wait_idle("post_reset");
        check("post_reset_grants", grant_log.size(), 2);
        if (grant_log.size() > 0) check("post_reset_first", grant_log[0], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
